// File: rtl/pll_pkg.sv
// Types and constants shared by the phase detector and the loop integrator.
// The error width is fixed here so both sides of the interface always agree.
package pll_pkg;

    localparam int W = 24;

    typedef logic signed [W-1:0] err_t;
    typedef logic        [W-2:0] cnt_t;

    localparam err_t ERR_MAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REF_FIRST = 2'd1,
        FB_FIRST  = 2'd2
    } pfd_state_t;

    // Saturate before negating so the most negative code is never produced.
    function automatic err_t signed_mag(input cnt_t mag, input logic neg);
        err_t v;
        v = err_t'({1'b0, mag});
        if (v > ERR_MAX) begin
            v = ERR_MAX;
        end
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/pfd_tdc_edge_det.sv
// Rising-edge detector: one register stage plus a history flop, both reset high.
// Latency: the rise is flagged combinationally in the cycle after the level is first sampled high.
// Backpressure: none.
module edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lvl,
    output logic o_rise
);

    logic r_d;
    logic r_dd;

    // History resets high so a level already asserted at reset release is not an edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d  <= 1'b1;
            r_dd <= 1'b1;
        end else begin
            r_d  <= i_lvl;
            r_dd <= r_d;
        end
    end

    assign o_rise = r_d & ~r_dd;

endmodule

// File: rtl/pfd_tdc.sv
// Counter PFD/TDC: signed cycle distance between ref and fb rising edges (optional PFD_DEADZONE_EN).
// Latency: result registered one cycle after the closing edge is detected; one-cycle strobes.
// Backpressure: none; the downstream integrator must accept every err_valid strobe.
module pfd_tdc
    import pll_pkg::*;
#(
    parameter int TIMEOUT  = 4096,
    parameter int DEADZONE = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic ref_in,
    input  logic fb_in,
    output err_t err,
    output logic err_valid,
    output logic slip,
    output logic timeout
);

    localparam cnt_t TO_CNT = cnt_t'(TIMEOUT);
    localparam cnt_t DZ_CNT = cnt_t'(DEADZONE);

`ifdef PFD_DEADZONE_EN
    localparam logic DZ_EN = 1'b1;
`else
    localparam logic DZ_EN = 1'b0;
`endif

    logic       w_ref_rise;
    logic       w_fb_rise;
    logic       w_lead_rise;
    logic       w_close_rise;
    logic       w_neg;
    cnt_t       w_count_inc;

    pfd_state_t r_state;
    cnt_t       r_count;
    err_t       r_err;
    logic       r_err_valid;
    logic       r_slip;
    logic       r_timeout;

    edge_det u_ref_edge (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_lvl   (ref_in),
        .o_rise  (w_ref_rise)
    );

    edge_det u_fb_edge (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_lvl   (fb_in),
        .o_rise  (w_fb_rise)
    );

    // REF_FIRST and FB_FIRST share one datapath: only the roles and the sign swap.
    assign w_neg        = (r_state == FB_FIRST);
    assign w_lead_rise  = w_neg ? w_fb_rise : w_ref_rise;
    assign w_close_rise = w_neg ? w_ref_rise : w_fb_rise;
    assign w_count_inc  = (r_count == '1) ? r_count : r_count + 1'b1;

    function automatic err_t normal_err(input cnt_t mag, input logic neg);
        if (DZ_EN && (mag <= DZ_CNT)) begin
            return '0;
        end
        return signed_mag(mag, neg);
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_err       <= '0;
            r_err_valid <= 1'b0;
            r_slip      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_err       <= '0;
            r_err_valid <= 1'b0;
            r_slip      <= 1'b0;
            r_timeout   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ref_rise && w_fb_rise) begin
                        r_err_valid <= 1'b1;
                    end else if (w_ref_rise) begin
                        r_state <= REF_FIRST;
                        r_count <= cnt_t'(1);
                    end else if (w_fb_rise) begin
                        r_state <= FB_FIRST;
                        r_count <= cnt_t'(1);
                    end
                end
                REF_FIRST, FB_FIRST: begin
                    if (w_close_rise) begin
                        r_err       <= normal_err(r_count, w_neg);
                        r_err_valid <= 1'b1;
                        if (w_lead_rise) begin
                            r_count <= cnt_t'(1);
                        end else begin
                            r_state <= IDLE;
                            r_count <= '0;
                        end
                    end else if (w_lead_rise) begin
                        // Slip: report what was measured and restart from the new leading edge.
                        r_err       <= signed_mag(r_count, w_neg);
                        r_err_valid <= 1'b1;
                        r_slip      <= 1'b1;
                        r_count     <= cnt_t'(1);
                    end else if (r_count >= TO_CNT) begin
                        r_err       <= w_neg ? -ERR_MAX : ERR_MAX;
                        r_err_valid <= 1'b1;
                        r_timeout   <= 1'b1;
                        r_state     <= IDLE;
                        r_count     <= '0;
                    end else begin
                        r_count <= w_count_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign err       = r_err;
    assign err_valid = r_err_valid;
    assign slip      = r_slip;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_pfd_tdc.sv
// Directed bench for pfd_tdc with TIMEOUT=16; expectations follow PFD_DEADZONE_EN when defined.
module tb_pfd_tdc;

`ifdef PFD_DEADZONE_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               ref_in;
    logic               fb_in;
    logic signed [23:0] err;
    logic               err_valid;
    logic               slip;
    logic               timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [23:0] cap_err  [0:63];
    logic               cap_vld  [0:63];
    logic               cap_slip [0:63];
    logic               cap_to   [0:63];
    logic signed [23:0] exp_err  [0:63];
    logic               exp_vld  [0:63];
    logic               exp_slip [0:63];
    logic               exp_to   [0:63];

    pfd_tdc #(.TIMEOUT(16), .DEADZONE(2)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .ref_in    (ref_in),
        .fb_in     (fb_in),
        .err       (err),
        .err_valid (err_valid),
        .slip      (slip),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Bit k of each mask is the level sampled at relative posedge k; outputs captured 1ns after it.
    task automatic run(input logic [63:0] rm, input logic [63:0] fm, input int n);
        for (int k = 0; k < n; k++) begin
            ref_in = rm[k];
            fb_in  = fm[k];
            @(posedge clk);
            #1;
            cap_err[k]  = err;
            cap_vld[k]  = err_valid;
            cap_slip[k] = slip;
            cap_to[k]   = timeout;
        end
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 64; k++) begin
            exp_err[k]  = '0;
            exp_vld[k]  = 1'b0;
            exp_slip[k] = 1'b0;
            exp_to[k]   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ref_in = 1'b1;
        fb_in  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({err, err_valid, slip, timeout} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_hold err=%0d vld=%b slip=%b to=%b want all 0", err, err_valid, slip, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_exp();
        run(mk(0, 9), mk(0, 9), 10);
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (cap_vld[k] !== 1'b0 || cap_err[k] !== 24'sd0 || cap_slip[k] !== 1'b0 || cap_to[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release k=%0d err=%0d vld=%b slip=%b to=%b want all 0",
                         k, cap_err[k], cap_vld[k], cap_slip[k], cap_to[k]);
            end
        end
    endtask

    task automatic test_ref_lead();
        clear_exp();
        exp_vld[16] = 1'b1;
        exp_err[16] = 24'sd5;
        run(mk(10, 21), mk(15, 21), 22);
        for (int k = 0; k < 22; k++) begin
            n_cmp++;
            if (cap_err[k] !== exp_err[k] || cap_vld[k] !== exp_vld[k] || cap_slip[k] !== exp_slip[k] || cap_to[k] !== exp_to[k]) begin
                n_fail++;
                $display("FAIL ref_lead k=%0d got err=%0d vld=%b slip=%b to=%b want err=%0d vld=%b slip=%b to=%b",
                         k, cap_err[k], cap_vld[k], cap_slip[k], cap_to[k], exp_err[k], exp_vld[k], exp_slip[k], exp_to[k]);
            end
        end
    endtask

    task automatic test_fb_lead();
        clear_exp();
        exp_vld[24] = 1'b1;
        exp_err[24] = -24'sd3;
        run(mk(23, 25), mk(20, 25), 26);
        for (int k = 0; k < 26; k++) begin
            n_cmp++;
            if (cap_err[k] !== exp_err[k] || cap_vld[k] !== exp_vld[k] || cap_slip[k] !== exp_slip[k] || cap_to[k] !== exp_to[k]) begin
                n_fail++;
                $display("FAIL fb_lead k=%0d got err=%0d vld=%b slip=%b to=%b want err=%0d vld=%b slip=%b to=%b",
                         k, cap_err[k], cap_vld[k], cap_slip[k], cap_to[k], exp_err[k], exp_vld[k], exp_slip[k], exp_to[k]);
            end
        end
    endtask

    task automatic test_same_edge();
        clear_exp();
        exp_vld[4] = 1'b1;
        run(mk(3, 5), mk(3, 5), 6);
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (cap_err[k] !== exp_err[k] || cap_vld[k] !== exp_vld[k] || cap_slip[k] !== exp_slip[k] || cap_to[k] !== exp_to[k]) begin
                n_fail++;
                $display("FAIL same_edge k=%0d got err=%0d vld=%b slip=%b to=%b want err=%0d vld=%b",
                         k, cap_err[k], cap_vld[k], cap_slip[k], cap_to[k], exp_err[k], exp_vld[k]);
            end
        end
    endtask

    task automatic test_slip();
        clear_exp();
        exp_vld[11]  = 1'b1;
        exp_slip[11] = 1'b1;
        exp_err[11]  = 24'sd8;
        exp_vld[14]  = 1'b1;
        exp_err[14]  = 24'sd3;
        run(mk(2, 4) | mk(10, 12), mk(13, 15), 18);
        for (int k = 0; k < 18; k++) begin
            n_cmp++;
            if (cap_err[k] !== exp_err[k] || cap_vld[k] !== exp_vld[k] || cap_slip[k] !== exp_slip[k] || cap_to[k] !== exp_to[k]) begin
                n_fail++;
                $display("FAIL slip k=%0d got err=%0d vld=%b slip=%b to=%b want err=%0d vld=%b slip=%b to=%b",
                         k, cap_err[k], cap_vld[k], cap_slip[k], cap_to[k], exp_err[k], exp_vld[k], exp_slip[k], exp_to[k]);
            end
        end
    endtask

    task automatic test_timeout();
        // Ref leads, no fb: count reaches 16 at posedge 18, timeout registered at posedge 19.
        clear_exp();
        exp_vld[19] = 1'b1;
        exp_to[19]  = 1'b1;
        exp_err[19] = 24'sd8388607;
        run(mk(2, 23), 64'd0, 24);
        for (int k = 0; k < 24; k++) begin
            n_cmp++;
            if (cap_err[k] !== exp_err[k] || cap_vld[k] !== exp_vld[k] || cap_slip[k] !== exp_slip[k] || cap_to[k] !== exp_to[k]) begin
                n_fail++;
                $display("FAIL timeout_ref k=%0d got err=%0d vld=%b to=%b want err=%0d vld=%b to=%b",
                         k, cap_err[k], cap_vld[k], cap_to[k], exp_err[k], exp_vld[k], exp_to[k]);
            end
        end
        // Closing edge exactly TIMEOUT cycles later is still a normal measurement.
        clear_exp();
        exp_vld[19] = 1'b1;
        exp_err[19] = 24'sd16;
        run(mk(2, 20), mk(18, 20), 21);
        for (int k = 0; k < 21; k++) begin
            n_cmp++;
            if (cap_err[k] !== exp_err[k] || cap_vld[k] !== exp_vld[k] || cap_slip[k] !== exp_slip[k] || cap_to[k] !== exp_to[k]) begin
                n_fail++;
                $display("FAIL timeout_edge k=%0d got err=%0d vld=%b to=%b want err=%0d vld=%b to=%b",
                         k, cap_err[k], cap_vld[k], cap_to[k], exp_err[k], exp_vld[k], exp_to[k]);
            end
        end
        clear_exp();
        exp_vld[19] = 1'b1;
        exp_to[19]  = 1'b1;
        exp_err[19] = -24'sd8388607;
        run(64'd0, mk(2, 23), 24);
        for (int k = 0; k < 24; k++) begin
            n_cmp++;
            if (cap_err[k] !== exp_err[k] || cap_vld[k] !== exp_vld[k] || cap_slip[k] !== exp_slip[k] || cap_to[k] !== exp_to[k]) begin
                n_fail++;
                $display("FAIL timeout_fb k=%0d got err=%0d vld=%b to=%b want err=%0d vld=%b to=%b",
                         k, cap_err[k], cap_vld[k], cap_to[k], exp_err[k], exp_vld[k], exp_to[k]);
            end
        end
        // Back in IDLE: coincident edges must give a zero measurement.
        clear_exp();
        exp_vld[3] = 1'b1;
        run(mk(2, 4), mk(2, 4), 5);
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (cap_err[k] !== exp_err[k] || cap_vld[k] !== exp_vld[k] || cap_slip[k] !== exp_slip[k] || cap_to[k] !== exp_to[k]) begin
                n_fail++;
                $display("FAIL timeout_idle k=%0d got err=%0d vld=%b want err=%0d vld=%b",
                         k, cap_err[k], cap_vld[k], exp_err[k], exp_vld[k]);
            end
        end
    endtask

    task automatic test_deadzone();
        logic [63:0] rm [0:2];
        logic [63:0] fm [0:2];
        int          vk [0:2];
        logic signed [23:0] ve [0:2];
        rm[0] = mk(2, 6); fm[0] = mk(4, 6); vk[0] = 5; ve[0] = DZ ? 24'sd0 : 24'sd2;
        rm[1] = mk(2, 6); fm[1] = mk(5, 6); vk[1] = 6; ve[1] = 24'sd3;
        rm[2] = mk(4, 6); fm[2] = mk(2, 6); vk[2] = 5; ve[2] = DZ ? 24'sd0 : -24'sd2;
        for (int t = 0; t < 3; t++) begin
            clear_exp();
            exp_vld[vk[t]] = 1'b1;
            exp_err[vk[t]] = ve[t];
            run(rm[t], fm[t], 7);
            for (int k = 0; k < 7; k++) begin
                n_cmp++;
                if (cap_err[k] !== exp_err[k] || cap_vld[k] !== exp_vld[k] || cap_slip[k] !== exp_slip[k] || cap_to[k] !== exp_to[k]) begin
                    n_fail++;
                    $display("FAIL deadzone t=%0d k=%0d got err=%0d vld=%b want err=%0d vld=%b",
                             t, k, cap_err[k], cap_vld[k], exp_err[k], exp_vld[k]);
                end
            end
        end
    endtask

    task automatic test_midreset();
        // Slip leaves REF_FIRST open with a strobe on the outputs; reset must clear both at once.
        run(mk(2, 3) | mk(6, 7), 64'd0, 8);
        n_cmp++;
        if (cap_vld[7] !== 1'b1 || cap_slip[7] !== 1'b1 || cap_err[7] !== 24'sd4) begin
            n_fail++;
            $display("FAIL midreset_pre err=%0d vld=%b slip=%b want err=4 vld=1 slip=1", cap_err[7], cap_vld[7], cap_slip[7]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({err, err_valid, slip, timeout} !== 27'd0) begin
            n_fail++;
            $display("FAIL midreset_async err=%0d vld=%b slip=%b to=%b want all 0", err, err_valid, slip, timeout);
        end
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // A surviving REF_FIRST would close on the fb edge at posedge 3 with a positive error.
        clear_exp();
        exp_vld[8] = 1'b1;
        exp_err[8] = -24'sd4;
        run(mk(7, 9), mk(3, 9), 10);
        for (int k = 0; k < 10; k++) begin
            n_cmp++;
            if (cap_err[k] !== exp_err[k] || cap_vld[k] !== exp_vld[k] || cap_slip[k] !== exp_slip[k] || cap_to[k] !== exp_to[k]) begin
                n_fail++;
                $display("FAIL midreset_post k=%0d got err=%0d vld=%b slip=%b to=%b want err=%0d vld=%b",
                         k, cap_err[k], cap_vld[k], cap_slip[k], cap_to[k], exp_err[k], exp_vld[k]);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        test_reset();
        test_ref_lead();
        test_fb_lead();
        test_same_edge();
        test_slip();
        test_timeout();
        test_deadzone();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pfd_tdc.md
Name: pfd_tdc

Overview:
- Counter-based phase-frequency detector / time-to-digital converter. It is the stage directly upstream of the loop integrator.
- Measures the clock-cycle distance between rising edges of the reference and feedback signals.
- Emits a one-cycle signed phase-error word. The error is zero on every other cycle, so the downstream accumulator integrates each measurement exactly once.

Parameters:
- W, 24, error word width; matches the integrator's signed 24-bit input.
- TIMEOUT, 4096, max cycles waited for the closing edge; must be < 2^(W-1)-1.
- DEADZONE, 2, magnitude at or below which error is forced to 0 (only with PFD_DEADZONE_EN).

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ref_in  input  1  reference level, synchronous to CLK.
- fb_in  input  1  divided feedback level, synchronous to CLK.
- err  output  W  signed phase error; positive = ref leads.
- err_valid  output  1  one-cycle strobe, high when err carries a measurement.
- slip  output  1  one-cycle strobe: same-side edge repeated before the opposite edge arrived.
- timeout  output  1  one-cycle strobe: TIMEOUT reached without a closing edge.

Behaviour:
- Reset (async, RST_N=0):
  - FSM to IDLE; count=0.
  - err=0, err_valid=0, slip=0, timeout=0.
  - Input history registers reset to 1, so a level already high at reset release is not an edge.
- Edge detect:
  - Inputs are registered once (ref_d, fb_d).
  - Rising edge = ref_d & ~ref_dd (same for fb).
  - "Edge at posedge a" means the input was first sampled high at posedge a.
- Measurement: ref edge at posedge a, fb edge at posedge b gives err = +(b-a). The fb-first case is symmetric and gives a negative error.
- Latency: err_valid is high during the cycle after posedge (closing edge + 1); all outputs are registered.
- err is 0 whenever err_valid=0.
- FSM states IDLE, REF_FIRST, FB_FIRST:
  - IDLE, both edges same cycle: emit err=0, valid=1, stay IDLE.
  - IDLE, ref edge only: go to REF_FIRST, count=1.
  - IDLE, fb edge only: go to FB_FIRST, count=1.
  - REF_FIRST, no edge: count++.
  - REF_FIRST, fb edge: emit +count, go to IDLE.
  - REF_FIRST, fb and ref edge same cycle: emit +count, stay REF_FIRST with count=1 (new measurement opened).
  - REF_FIRST, ref edge without fb (cycle slip): emit +count, slip=1, stay REF_FIRST, count=1.
  - FB_FIRST: mirror of REF_FIRST with negated sign.
  - Any state, count reaches TIMEOUT with no closing edge: emit ±(2^(W-1)-1) (sign by leading side), timeout=1, go to IDLE.
- Arithmetic:
  - count is unsigned W-1 bits.
  - Emitted magnitude saturates at 2^(W-1)-1.
  - Negation is applied after saturation, so -2^(W-1) is never produced.
- slip, timeout and err_valid may coincide with err_valid.
- Reset mid-measurement discards the measurement; no output is emitted.

Optional Feature:
- Macro PFD_DEADZONE_EN.
- Defined: a normal (non-timeout, non-slip) measurement with |err| <= DEADZONE emits err=0 with err_valid still 1.
- Undefined: DEADZONE is ignored and the exact count is emitted.
- Timeout and slip outputs are unaffected either way.

Decomposition:
- Shared package pll_pkg:
  - W constant (24), shared with the integrator.
  - Signed error typedef err_t.
  - ERR_MAX = 2^(W-1)-1.
  - FSM state enum pfd_state_t.
- One natural sub-module: edge_det, a 2-flop rising-edge detector with async active-low reset (history flop reset to 1). Instantiated for ref and fb.

Test Plan:
- Reset release with ref_in=fb_in=1 held high -> no err_valid for 10 cycles, err=0.
- Ref edge at posedge 10, fb edge at posedge 15 -> single err_valid cycle after posedge 16 with err=+5; err=0 all other cycles.
- Fb edge at posedge 20, ref edge at posedge 23 -> err=-3.
- Ref and fb edges at the same posedge -> err=0, err_valid=1.
- Ref edge with fb held low, TIMEOUT=16 -> timeout=1, err=+8388607, FSM back to IDLE.
- Ref edges at posedges 0 and 8, no fb -> slip=1, err=+8; fb edge at posedge 11 -> err=+3.
- With PFD_DEADZONE_EN defined: ref-to-fb gap of 2 cycles -> err=0, err_valid=1; gap of 3 -> err=+3.
- Assert RST_N mid-measurement -> outputs 0 immediately; the next clean pair measures correctly.
